issue_queue_enq_arb: RTL and testbench

Round-robin enqueue arbiter sharing the single `in_valid/in_data/in_ready` port of `issue_queue_2picker` between `NREQ` requesters. It is registered through a one-entry stage, so the queue sees a clean registered `in_valid`. It also tracks queue occupancy from the queue's enqueue and dual-pop handshakes, with a sticky error flag on accounting violations. The block sits directly upstream of the queue; its `q_*` ports wire to the queue's ports.

---
 rtl/issue_queue_pkg.sv | 16 +
 rtl/issue_queue_enq_arb_rr_pick.sv | 41 ++++
 rtl/issue_queue_enq_arb.sv | 128 ++++++++++++
 tb/tb_issue_queue_enq_arb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_queue_pkg.sv
// Shared constants and types for the issue queue and its enqueue arbiter.
// No logic; compile-time definitions only.
// Not applicable (no handshakes).
package issue_queue_pkg;

    // Payload width and capacity shared with issue_queue_2picker.
    localparam int IQ_DATA_W = 8;
    localparam int IQ_DEPTH  = 4;

    // Default number of enqueue requesters and the matching id width.
    localparam int IQ_NREQ   = 3;
    localparam int IQ_ID_W   = $clog2(IQ_NREQ);

    typedef logic [IQ_ID_W-1:0] req_id_t;

endpackage

// File: rtl/issue_queue_enq_arb_rr_pick.sv
// Round-robin selector: first asserted request at or after ptr_i, wrapping modulo NREQ.
// Purely combinational, zero latency.
// No backpressure; the caller gates the grant with its own ready.
module rr_pick
    import issue_queue_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [ID_W-1:0] gnt_id_o,
    output logic            any_o
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int                sum;

    // Rotate requests so bit k is requester (ptr+k) mod NREQ, then take the lowest set bit.
    always_comb begin
        dbl      = {req_i, req_i};
        rot      = NREQ'(dbl >> ptr_i);
        any_o    = 1'b0;
        gnt_id_o = '0;
        sum      = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_o && rot[k]) begin
                any_o = 1'b1;
                sum   = int'(ptr_i) + k;
                if (sum >= NREQ) begin
                    sum = sum - NREQ;
                end
                gnt_id_o = ID_W'(sum);
            end
        end
        gnt_o = any_o ? (NREQ'(1) << gnt_id_o) : '0;
    end

endmodule

// File: rtl/issue_queue_enq_arb.sv
// Round-robin enqueue arbiter with a one-entry output stage and queue occupancy tracking.
// Latency: requester accept to q_in_valid is 1 cycle; sustains 1 entry/cycle.
// Backpressure: q_in_ready low with a full stage drops every req_ready; stage refills on drain.
module issue_queue_enq_arb
    import issue_queue_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int DATA_W = IQ_DATA_W,
    parameter int DEPTH  = IQ_DEPTH,
    parameter int OCC_W  = $clog2(DEPTH+1),
    parameter int ID_W   = $clog2(NREQ)
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   q_in_valid,
    output logic [DATA_W-1:0]      q_in_data,
    input  logic                   q_in_ready,
    input  logic                   q_pop0,
    input  logic                   q_pop1,
    output logic [ID_W-1:0]        stage_id,
    output logic [OCC_W-1:0]       occupancy,
    output logic                   acct_err
);

    // Two guard bits so enqueue/pop arithmetic never wraps before the bound checks.
    localparam int CW = OCC_W + 2;

    logic              stage_valid_q, stage_valid_d;
    logic [DATA_W-1:0] stage_data_q,  stage_data_d;
    logic [ID_W-1:0]   stage_id_q,    stage_id_d;
    logic [ID_W-1:0]   rr_ptr_q,      rr_ptr_d;
    logic [OCC_W-1:0]  occ_q,         occ_d;
    logic              acct_err_q,    acct_err_d;

    logic [NREQ-1:0]   gnt;
    logic [ID_W-1:0]   gnt_id;
    logic              any_req;
    logic              enq_fire;
    logic              stage_free;
    logic              acc;
    logic [CW-1:0]     avail;
    logic [CW-1:0]     pops;
    logic [CW-1:0]     net;

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req_i    (req_valid),
        .ptr_i    (rr_ptr_q),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id),
        .any_o    (any_req)
    );

    // The stage counts as free when it is empty or draining this cycle (bypass refill).
    assign enq_fire   = stage_valid_q && q_in_ready;
    assign stage_free = !stage_valid_q || q_in_ready;
    assign req_ready  = (stage_free && !sys_rst) ? gnt : '0;
    assign acc        = any_req && stage_free && !sys_rst;

    // Stage load on accept, clear on drain without refill; pointer moves past the winner.
    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_data_d  = stage_data_q;
        stage_id_d    = stage_id_q;
        rr_ptr_d      = rr_ptr_q;
        if (acc) begin
            stage_valid_d = 1'b1;
            stage_data_d  = req_data[int'(gnt_id)*DATA_W +: DATA_W];
            stage_id_d    = gnt_id;
            rr_ptr_d      = (int'(gnt_id) == NREQ-1) ? '0 : gnt_id + ID_W'(1);
        end else if (enq_fire) begin
            stage_valid_d = 1'b0;
        end
    end

    // Occupancy update with saturation; out-of-range results latch the sticky error.
    // A lone q_pop1 is ignored because the second output only pops alongside the first.
    always_comb begin
        avail      = CW'(occ_q) + CW'(enq_fire);
        pops       = CW'(q_pop0) + CW'(q_pop0 && q_pop1);
        net        = '0;
        occ_d      = occ_q;
        acct_err_d = acct_err_q;
        if (pops > avail) begin
            occ_d      = '0;
            acct_err_d = 1'b1;
        end else begin
            net = avail - pops;
            if (net > CW'(DEPTH)) begin
                occ_d      = OCC_W'(DEPTH);
                acct_err_d = 1'b1;
            end else begin
                occ_d = net[OCC_W-1:0];
            end
        end
    end

    // State registers; reset discards any staged entry.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            stage_id_q    <= '0;
            rr_ptr_q      <= '0;
            occ_q         <= '0;
            acct_err_q    <= 1'b0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            stage_id_q    <= stage_id_d;
            rr_ptr_q      <= rr_ptr_d;
            occ_q         <= occ_d;
            acct_err_q    <= acct_err_d;
        end
    end

    assign q_in_valid = stage_valid_q;
    assign q_in_data  = stage_data_q;
    assign stage_id   = stage_id_q;
    assign occupancy  = occ_q;
    assign acct_err   = acct_err_q;

endmodule

// File: tb/tb_issue_queue_enq_arb.sv
// Bench for issue_queue_enq_arb driving a behavioural two-output queue model.
// Scoreboard: accepted requester data pushed on grant, popped on queue output.
// Override mode lets the bench force q_in_ready / pop handshakes directly.
module tb_issue_queue_enq_arb;
    import issue_queue_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_ready;
    logic        q_in_valid;
    logic [7:0]  q_in_data;
    logic        q_in_ready;
    logic        q_pop0;
    logic        q_pop1;
    req_id_t     stage_id;
    logic [2:0]  occupancy;
    logic        acct_err;

    logic        out0_ready, out1_ready;
    logic        ovr, ovr_in_ready, ovr_pop0, ovr_pop1;

    logic [7:0]  mq[$];
    int          m_cnt = 0;
    logic [7:0]  m_d0 = '0, m_d1 = '0;
    logic        f_act = 1'b0, f_enq = 1'b0, f_pop0 = 1'b0, f_pop1 = 1'b0;
    logic [7:0]  f_dat = '0;

    logic [7:0]  sb[$];
    int          exp_gnt[$];
    int          tests = 0;
    int          fails = 0;
    int          seen77 = 0;

    always #5 sys_clk = ~sys_clk;

    issue_queue_enq_arb dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .q_in_valid (q_in_valid),
        .q_in_data  (q_in_data),
        .q_in_ready (q_in_ready),
        .q_pop0     (q_pop0),
        .q_pop1     (q_pop1),
        .stage_id   (stage_id),
        .occupancy  (occupancy),
        .acct_err   (acct_err)
    );

    assign q_in_ready = ovr ? ovr_in_ready : (m_cnt < IQ_DEPTH);
    assign q_pop0     = ovr ? ovr_pop0 : (m_cnt >= 1 && out0_ready);
    assign q_pop1     = ovr ? ovr_pop1 : (m_cnt >= 2 && out0_ready && out1_ready);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sb_next();
        if (sb.size() > 0) return {24'h0, sb.pop_front()};
        return 32'hDEAD;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    // Queue model state advances just after each edge from handshakes seen at the negedge.
    always @(posedge sys_clk) begin
        #1;
        if (sys_rst) begin
            mq.delete();
        end else if (f_act) begin
            if (f_pop0) void'(mq.pop_front());
            if (f_pop1) void'(mq.pop_front());
            if (f_enq) mq.push_back(f_dat);
        end
        m_cnt = mq.size();
        m_d0  = (m_cnt > 0) ? mq[0] : 8'h00;
        m_d1  = (m_cnt > 1) ? mq[1] : 8'h00;
    end

    // Monitor: check grants and queue output data mid-cycle.
    always @(negedge sys_clk) begin
        f_act  = !ovr;
        f_enq  = 1'b0;
        f_pop0 = 1'b0;
        f_pop1 = 1'b0;
        f_dat  = q_in_data;
        if (!sys_rst) begin
            for (int i = 0; i < 3; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    if (exp_gnt.size() > 0) chk("grant_id", i, exp_gnt.pop_front());
                    else chk("grant_unexpected", i, 99);
                    sb.push_back(req_data[i*8 +: 8]);
                end
            end
            if (q_in_valid && q_in_ready && q_in_data == 8'h77) seen77++;
            if (!ovr) begin
                f_enq  = q_in_valid && q_in_ready;
                f_pop0 = q_pop0;
                f_pop1 = q_pop1;
                if (q_pop0) chk("out0_data", {24'h0, m_d0}, sb_next());
                if (q_pop1) chk("out1_data", {24'h0, m_d1}, sb_next());
            end
        end
    end

    initial begin
        sys_rst = 1'b1; req_valid = 3'b111; req_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        ovr = 1'b0; ovr_in_ready = 1'b0; ovr_pop0 = 1'b0; ovr_pop1 = 1'b0;

        // Reset state
        tick(); tick(); #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_q_in_valid", q_in_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_acct_err", acct_err, 0);
        chk("rst_stage_id", stage_id, 0);
        req_valid = 3'b000; sys_rst = 1'b0;

        // Single requester
        req_valid = 3'b010; req_data[15:8] = 8'h11; exp_gnt.push_back(1);
        #1 chk("single_req_ready", req_ready, 3'b010);
        tick(); req_valid = 3'b000; #1;
        chk("single_q_in_valid", q_in_valid, 1);
        chk("single_q_in_data", q_in_data, 8'h11);
        chk("single_stage_id", stage_id, 1);
        tick(); #1;
        chk("single_occ_1", occupancy, 1);
        chk("single_stage_empty", q_in_valid, 0);
        out0_ready = 1'b1; tick(); out0_ready = 1'b0; #1;
        chk("single_occ_0", occupancy, 0);

        sys_rst = 1'b1; tick(); sys_rst = 1'b0;

        // Fairness with continuous dual drain
        out0_ready = 1'b1; out1_ready = 1'b1;
        req_valid = 3'b111; req_data = {8'hC0, 8'hB0, 8'hA0};
        for (int r = 0; r < 2; r++) for (int i = 0; i < 3; i++) exp_gnt.push_back(i);
        repeat (6) tick();
        req_valid = 3'b000;
        repeat (6) tick(); #1;
        chk("fair_sb_empty", sb.size(), 0);
        chk("fair_gnt_done", exp_gnt.size(), 0);
        chk("fair_occ", occupancy, 0);
        out0_ready = 1'b0; out1_ready = 1'b0;

        // Backpressure: fill to DEPTH, 5th entry held in stage
        req_valid = 3'b001;
        repeat (6) exp_gnt.push_back(0);
        for (int k = 0; k < 5; k++) begin
            req_data[7:0] = 8'h51 + 8'(k);
            tick();
        end
        req_data[7:0] = 8'h66; #1;
        chk("bp_req_ready", req_ready, 0);
        chk("bp_occ_full", occupancy, 4);
        tick(); #1;
        chk("bp_hold_data", q_in_data, 8'h55);
        chk("bp_hold_valid", q_in_valid, 1);
        chk("bp_hold_id", stage_id, 0);
        chk("bp_req_ready_2", req_ready, 0);
        chk("bp_no_err", acct_err, 0);
        out0_ready = 1'b1; tick(); out0_ready = 1'b0; #1;
        chk("bp_occ_after_pop", occupancy, 3);
        chk("bp_req_ready_open", req_ready, 3'b001);
        tick(); req_valid = 3'b000; #1;
        chk("bp_occ_refill", occupancy, 4);
        chk("bp_next_stage", q_in_data, 8'h66);
        out0_ready = 1'b1; out1_ready = 1'b1;
        repeat (6) tick();
        out0_ready = 1'b0; out1_ready = 1'b0; #1;
        chk("bp_drained_occ", occupancy, 0);
        chk("bp_sb_empty", sb.size(), 0);

        // Dual pop at full with same-cycle enqueue
        req_valid = 3'b100;
        repeat (5) exp_gnt.push_back(2);
        for (int k = 0; k < 5; k++) begin
            req_data[23:16] = 8'h71 + 8'(k);
            tick();
        end
        req_valid = 3'b000; #1;
        chk("dp_occ_full", occupancy, 4);
        ovr = 1'b1; ovr_in_ready = 1'b1; ovr_pop0 = 1'b1; ovr_pop1 = 1'b1;
        tick(); #1;
        chk("dp_occ_3", occupancy, 3);
        chk("dp_no_err", acct_err, 0);
        chk("dp_stage_drained", q_in_valid, 0);
        ovr_in_ready = 1'b0; ovr_pop1 = 1'b0;
        tick(); #1;
        chk("dp_occ_2", occupancy, 2);
        ovr_pop0 = 1'b0; ovr_pop1 = 1'b1;
        tick(); #1;
        chk("pop1_only_occ", occupancy, 2);
        chk("pop1_only_no_err", acct_err, 0);

        // Accounting underflow
        ovr_pop0 = 1'b1; ovr_pop1 = 1'b0;
        tick(); #1;
        chk("viol_pre_occ", occupancy, 1);
        ovr_pop1 = 1'b1;
        tick(); #1;
        chk("viol_err", acct_err, 1);
        chk("viol_occ_sat", occupancy, 0);
        ovr_pop0 = 1'b0; ovr_pop1 = 1'b0;
        tick(); #1;
        chk("viol_sticky", acct_err, 1);

        // Reset mid-transfer discards a staged entry
        req_valid = 3'b001; req_data[7:0] = 8'h77; exp_gnt.push_back(0);
        #1 chk("mid_req_ready", req_ready, 3'b001);
        tick(); req_valid = 3'b000; #1;
        chk("mid_staged_valid", q_in_valid, 1);
        chk("mid_staged_data", q_in_data, 8'h77);
        tick();
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        ovr = 1'b0; ovr_in_ready = 1'b0; ovr_pop0 = 1'b0; ovr_pop1 = 1'b0;
        sb.delete(); exp_gnt.delete(); #1;
        chk("mid_rst_valid", q_in_valid, 0);
        chk("mid_rst_occ", occupancy, 0);
        chk("mid_rst_err", acct_err, 0);

        // Pointer back at 0: requesters 0 and 2 valid, 0 must win first
        req_valid = 3'b101; req_data = {8'h99, 8'h00, 8'h88};
        exp_gnt.push_back(0); exp_gnt.push_back(2);
        #1 chk("rst_ptr_grant", req_ready, 3'b001);
        tick(); req_valid = 3'b100;
        tick(); req_valid = 3'b000;
        out0_ready = 1'b1; out1_ready = 1'b1;
        repeat (5) tick(); #1;
        chk("post_sb_empty", sb.size(), 0);
        chk("post_gnt_done", exp_gnt.size(), 0);
        chk("post_occ", occupancy, 0);
        chk("no_77_delivered", seen77, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
